phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter PHASES, default 8, phases per full instruction cycle; legal range 2..16.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 Localparam PW = clog2(PHASES+1), width of phase index and length fields.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low: 0 resets immediately, release is sampled on clk.
REQ-006 run  input  1  level enable; 1 = keep issuing instruction cycles.
REQ-007 mode_step  input  1  1 = single-step mode, one instruction per step pulse.
REQ-008 step  input  1  single-step request, sampled only in IDLE.
REQ-009 stall  input  1  1 = hold current phase (memory/ALU wait).
REQ-010 instr_len  input  PW  phases used by current instruction, from decode.
REQ-011 phase_en  output  PHASES  registered one-hot phase enable, replaces gated phase clocks.
REQ-012 phase_idx  output  PW  registered index of active phase.
REQ-013 busy  output  1  1 while an instruction cycle is in progress.
REQ-014 instr_done  output  1  one-cycle pulse when the last phase of an instruction completes.
REQ-015 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-016 Two states, IDLE and ACTIVE; phase_en SHALL be all-zero in IDLE and exactly one-hot in ACTIVE.
REQ-017 IDLE -> ACTIVE at phase 0 when run=1 and (mode_step=0 or step=1); otherwise remain IDLE.
REQ-018 Phase 0 SHALL be asserted in the first ACTIVE cycle; latency from qualifying run/step sample to phase_en[0]=1 is one clock.
REQ-019 In ACTIVE with stall=0, phase_idx SHALL advance by one per clock; with stall=1, phase_idx and phase_en SHALL hold unchanged.
REQ-020 Effective length L SHALL be captured from instr_len on the clock that leaves phase 1 (first non-stalled phase-1 cycle); L defaults to PHASES until captured.
REQ-021 instr_len values below 2 or above PHASES SHALL be clamped to 2 and PHASES respectively.
REQ-022 When phase_idx = L-1 and stall=0: instr_done pulses next cycle, instr_count increments by 1, L resets to PHASES.
REQ-023 At that last-phase advance: if run=1 and mode_step=0, next phase is 0 (back-to-back, no bubble); otherwise go to IDLE.
REQ-024 Deasserting run or asserting mode_step mid-instruction SHALL NOT truncate it; the instruction completes, then IDLE.
REQ-025 stall on the last phase SHALL delay instr_done and the count increment until stall drops.
REQ-026 instr_count SHALL wrap from 2^CNT_W-1 to 0 without any other effect.
REQ-027 busy SHALL equal 1 exactly when state is ACTIVE.
REQ-028 step asserted while ACTIVE SHALL be ignored (not queued).

Reset
REQ-029 On reset=0: state IDLE, phase_en=0, phase_idx=0, busy=0, instr_done=0, instr_count=0, L=PHASES, asynchronously.
REQ-030 Reset asserted mid-instruction SHALL abort it with no instr_done and no count increment.
REQ-031 After reset release, first possible phase_en[0] is one clock after the first clk edge sampling run=1.

Verification
REQ-032 PHASES=8, run=1, mode_step=0, instr_len=8, stall=0 for 20 clocks -> phase_en cycles 01,02,...,80,01,...; instr_done pulses every 8 clocks; instr_count=2 after 16 active clocks.
REQ-033 instr_len=3 held at phase 1 -> phases 0,1,2 then 0; instr_done every 3 clocks; instr_len=0 -> clamps to 2; instr_len=15 -> clamps to 8.
REQ-034 stall=1 for 3 clocks during phase 4 -> phase_en=10h held 4 clocks total; instr_done delayed by 3 clocks; count unaffected otherwise.
REQ-035 mode_step=1, run=1, one-cycle step pulse -> exactly one instruction (8 phases), one instr_done, return to IDLE with phase_en=0; step pulse while busy ignored.
REQ-036 run dropped at phase 2 -> phases 3..7 still execute, instr_done pulses, then IDLE; reset=0 at phase 5 of next run -> immediate phase_en=0, instr_count unchanged.
REQ-037 CNT_W=4, run 16 instructions from reset -> instr_count returns to 0 after the 16th instr_done, sequencing uninterrupted.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Control and status bundle between an instruction sequencer and its driver.
// The slave side is the sequencer: it consumes run/step/stall/length and produces phase status.
interface phase_sequencer_if #(
  parameter int PHASES = 8,
  parameter int CNT_W  = 32
);
  localparam int PW = $clog2(PHASES + 1);

  logic              run;
  logic              mode_step;
  logic              step;
  logic              stall;
  logic [PW-1:0]     instr_len;
  logic [PHASES-1:0] phase_en;
  logic [PW-1:0]     phase_idx;
  logic              busy;
  logic              instr_done;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run, mode_step, step, stall, instr_len,
    input  phase_en, phase_idx, busy, instr_done, instr_count
  );

  modport slave (
    input  run, mode_step, step, stall, instr_len,
    output phase_en, phase_idx, busy, instr_done, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: one-hot registered phase enables, variable-length instructions,
// stall hold, free-run or single-step issue, and a wrapping retired-instruction counter.
module phase_sequencer #(
  parameter int PHASES = 8,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave seq
);
  localparam int PW = $clog2(PHASES + 1);
  localparam logic [PW-1:0]     MAX_LEN   = PW'(PHASES);
  localparam logic [PW-1:0]     MIN_LEN   = PW'(2);
  localparam logic [PW-1:0]     IDX_ONE   = PW'(1);
  localparam logic [PHASES-1:0] EN_FIRST  = PHASES'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [PHASES-1:0] en_q, en_d;
  logic [PW-1:0]     len_q, len_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [PW-1:0]     len_in;
  logic [PW-1:0]     cur_len;

  always_comb begin
    len_in = seq.instr_len;
    if (seq.instr_len < MIN_LEN) begin
      len_in = MIN_LEN;
    end else if (seq.instr_len > MAX_LEN) begin
      len_in = MAX_LEN;
    end
  end

  // Length is latched when leaving phase 1, so phase 1 itself must already see the decoded value
  // for a 2-phase instruction to terminate there.
  assign cur_len = (idx_q == IDX_ONE) ? len_in : len_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    len_d   = len_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (seq.run && (!seq.mode_step || seq.step)) begin
          state_d = ACTIVE;
          idx_d   = '0;
          en_d    = EN_FIRST;
        end
      end
      ACTIVE: begin
        if (!seq.stall) begin
          if (idx_q == cur_len - IDX_ONE) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            len_d   = MAX_LEN;
            idx_d   = '0;
            if (seq.run && !seq.mode_step) begin
              en_d = EN_FIRST;
            end else begin
              state_d = IDLE;
              en_d    = '0;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
            en_d  = en_q << 1;
            if (idx_q == IDX_ONE) begin
              len_d = len_in;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        en_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      len_q   <= MAX_LEN;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      len_q   <= len_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign seq.phase_en    = en_q;
  assign seq.phase_idx   = idx_q;
  assign seq.busy        = (state_q == ACTIVE);
  assign seq.instr_done  = done_q;
  assign seq.instr_count = count_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized scoreboard bench for phase_sequencer (PHASES=8, CNT_W=4 so the counter wraps often).
module tb_phase_sequencer;
  localparam int PHASES = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [PHASES-1:0] en;
    logic [3:0]        idx;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cnt;
    int                cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cycle;
  exp_t exp_q[$];

  // Reference: one instruction in flight described by its current phase number and length.
  bit m_active;
  int m_ph;
  int m_len;
  int m_cnt;
  bit m_done;

  phase_sequencer_if #(.PHASES(PHASES), .CNT_W(CNT_W)) ifc ();

  phase_sequencer #(.PHASES(PHASES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp_len(input int l);
    if (l < 2) return 2;
    if (l > PHASES) return PHASES;
    return l;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ph     = 0;
    m_len    = PHASES;
    m_cnt    = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit ms, input bit st, input bit sl, input int len);
    int eff;
    m_done = 1'b0;
    if (!m_active) begin
      if (r && (!ms || st)) begin
        m_active = 1'b1;
        m_ph     = 0;
      end
    end else if (!sl) begin
      eff = (m_ph == 1) ? clamp_len(len) : m_len;
      if (m_ph == 1) m_len = clamp_len(len);
      if (m_ph == eff - 1) begin
        m_done = 1'b1;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_len  = PHASES;
        m_ph   = 0;
        if (!(r && !ms)) m_active = 1'b0;
      end else begin
        m_ph = m_ph + 1;
      end
    end
  endtask

  task automatic drive_cycle(input bit rst_v, input bit r, input bit ms, input bit st,
                             input bit sl, input int len);
    exp_t e;
    bit   was_up;
    @(negedge clk);
    #1;
    was_up         = reset;
    reset          = rst_v;
    ifc.run        = r;
    ifc.mode_step  = ms;
    ifc.step       = st;
    ifc.stall      = sl;
    ifc.instr_len  = 4'(len);
    if (!rst_v) begin
      model_reset();
      if (was_up) begin
        #1;
        tests++;
        if (ifc.phase_en !== '0 || ifc.busy !== 1'b0 || ifc.instr_count !== '0) begin
          fails++;
          $display("FAIL async_reset cycle%0d: got en=%h busy=%b cnt=%0d, expected en=00 busy=0 cnt=0",
                   cycle, ifc.phase_en, ifc.busy, ifc.instr_count);
        end
      end
    end else begin
      model_step(r, ms, st, sl, len);
    end
    e.en   = m_active ? PHASES'(1 << m_ph) : '0;
    e.idx  = 4'(m_ph);
    e.busy = m_active;
    e.done = m_done;
    e.cnt  = CNT_W'(m_cnt);
    e.cyc  = cycle;
    exp_q.push_back(e);
    cycle++;
  endtask

  // Monitor: every cycle the DUT presents a full status word; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (ifc.phase_en !== e.en || ifc.phase_idx !== e.idx || ifc.busy !== e.busy ||
            ifc.instr_done !== e.done || ifc.instr_count !== e.cnt) begin
          fails++;
          $display("FAIL status cycle%0d: got en=%h idx=%0d busy=%b done=%b cnt=%0d, expected en=%h idx=%0d busy=%b done=%b cnt=%0d",
                   e.cyc, ifc.phase_en, ifc.phase_idx, ifc.busy, ifc.instr_done, ifc.instr_count,
                   e.en, e.idx, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    cycle = 0;
    reset = 1'b0;
    ifc.run = 1'b0;
    ifc.mode_step = 1'b0;
    ifc.step = 1'b0;
    ifc.stall = 1'b0;
    ifc.instr_len = '0;
    model_reset();

    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    // Free-run full-length instructions, then short and out-of-range lengths.
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    repeat (30) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    // Stalls at random points of full-length instructions.
    repeat (100) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, ($urandom % 4) == 0, 8);
    // Single-step mode, including step pulses while busy.
    repeat (150) drive_cycle(1'b1, 1'b1, 1'b1, ($urandom % 10) == 0, 1'b0, 8);
    // Run dropped mid-instruction.
    repeat (150) drive_cycle(1'b1, ($urandom % 12) != 0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 15));
    // Everything randomized, including occasional mid-instruction reset.
    repeat (2500) drive_cycle(($urandom % 150) != 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
                              ($urandom % 4) == 0, ($urandom % 4) == 0, $urandom_range(0, 15));
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
